// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver.
// Scans DIGITS digits with a REFRESH_DIV-cycle dwell per digit. New values
// are double-buffered so a frame is never torn. Optional leading-zero blanking
// is supported. All display outputs are registered and active-low.
module seven_seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic [IW-1:0]         digit_idx
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic                tick, frame_bnd;
  logic [IW-1:0]       idx_nxt;
  logic [4*DIGITS-1:0] pend_val, shadow_val, shadow_val_nxt;
  logic [DIGITS-1:0]   pend_dp, shadow_dp, shadow_dp_nxt;
  logic                pend_vld;
  logic [DIGITS-1:0]   zero_up;
  logic [3:0]          nib;
  logic                blank;
  logic [DIGITS-1:0]   an_nxt;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Next-state scan index and shadow contents. Outputs are built from these,
  // so the display changes on the same edge as digit_idx and the shadow.
  always_comb begin
    tick           = (cnt == CNT_LAST);
    frame_bnd      = tick && (digit_idx == IDX_LAST);
    idx_nxt        = digit_idx;
    if (tick)
      idx_nxt = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    shadow_val_nxt = shadow_val;
    shadow_dp_nxt  = shadow_dp;
    if (frame_bnd) begin
      // A load in the boundary cycle bypasses the pending stage.
      if (load) begin
        shadow_val_nxt = value;
        shadow_dp_nxt  = dp;
      end else if (pend_vld) begin
        shadow_val_nxt = pend_val;
        shadow_dp_nxt  = pend_dp;
      end
    end
  end

  // zero_up[i] = nibbles i..DIGITS-1 of the next shadow are all zero.
  always_comb begin
    zero_up = '0;
    zero_up[DIGITS-1] = (shadow_val_nxt[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--)
      zero_up[i] = zero_up[i+1] && (shadow_val_nxt[4*i +: 4] == 4'h0);
  end

  // Select the nibble and anode for the digit that will be lit next cycle.
  always_comb begin
    nib   = shadow_val_nxt[{idx_nxt, 2'b00} +: 4];
    blank = blank_lz && (idx_nxt != '0) && zero_up[idx_nxt];
    an_nxt = '1;
    for (int i = 0; i < DIGITS; i++)
      an_nxt[i] = ~(en && (idx_nxt == IW'(i)));
  end

  // Refresh divider and digit scan.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else begin
      cnt       <= tick ? '0 : cnt + 1'b1;
      digit_idx <= idx_nxt;
    end
  end

  // Pending/shadow double buffer; the last load in a frame wins.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else begin
      shadow_val <= shadow_val_nxt;
      shadow_dp  <= shadow_dp_nxt;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp;
      end
      if (frame_bnd)
        pend_vld <= 1'b0;
      else if (load)
        pend_vld <= 1'b1;
    end
  end

  // Registered active-low display pins; en=0 blanks everything.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      seg  <= 7'h7F;
      dp_n <= 1'b1;
      an   <= '1;
    end else begin
      seg  <= (!en || blank) ? 7'h7F : hex_to_seg(nib);
      dp_n <= ~(en && shadow_dp_nxt[idx_nxt]);
      an   <= an_nxt;
    end
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It extends the single-digit hex decoder with several features: a configurable digit count, a refresh divider that scans the digits, frame-synchronous (tear-free) value loading, per-digit decimal points and optional leading-zero blanking. It sits between the UART status/data registers and the board display pins. Segment, decimal-point and anode outputs are all active-low and registered.

## Interface
- DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles each digit stays lit; must be ≥ 2.
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-low reset.
- en  input  1  display enable; 0 blanks all outputs, scanning continues.
- value  input  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i] drives digit i, where digit 0 is the rightmost.
- load  input  1  single-cycle strobe that captures value (and dp) for the next frame.
- dp  input  DIGITS  decimal point request per digit (1 = lit); captured with load.
- blank_lz  input  1  1 = suppress leading zeros (quasi-static level, sampled each cycle).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point of the active digit, active-low.
- an  output  DIGITS  anode selects, active-low, one-hot-low while enabled.
- digit_idx  output  max(1,$clog2(DIGITS))  index of the currently lit digit.

## Operation
- Divider: cnt counts 0..REFRESH_DIV-1 and wraps to 0. The wrap cycle is the "tick".
- Scan: on each tick, digit_idx advances by 1 and wraps from DIGITS-1 to 0. A "frame boundary" is a tick where digit_idx = DIGITS-1.
- Double buffering:
  - load=1 writes value/dp into the pending regs and sets pend_vld. Multiple loads within a frame: the last one wins.
  - At a frame boundary with pend_vld=1, pending moves into the shadow regs and pend_vld clears.
  - load coinciding with a frame boundary: the current-cycle value/dp bypasses straight into the shadow regs, and pend_vld ends at 0.
- Decode of shadow nibble n, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E (hex)
- Leading-zero blank: digit i (i ≥ 1) is blank when blank_lz=1 and shadow nibbles i..DIGITS-1 are all 0. Digit 0 is never blanked. A blank digit drives seg=7F, but its anode is still driven and its dp is still honoured.
- Outputs while en=1:
  - an = ~(1<<digit_idx)
  - seg = decode (or 7F when blanked)
  - dp_n = ~shadow_dp[digit_idx]
- Outputs while en=0: an all 1s, seg=7F, dp_n=1. Counter, index and buffering keep running.
- DIGITS=1: digit_idx is constant 0, and every tick is a frame boundary.

## Timing
- Reset (RST=0 at an edge) takes effect at that edge:
  - cnt=0, digit_idx=0
  - pending, shadow and pend_vld = 0
  - seg=7F, dp_n=1, an all 1s
- Reset asserted mid-frame aborts the scan and discards any pending load.
- The first lit output appears on the edge after RST is released with en=1: digit 0 shows 40 (shadow=0).
- seg/dp_n/an are registered. They are computed from the next-state index and shadow, so they change on the same edge as digit_idx. There are no combinational paths from inputs to outputs.
- An en change reaches the outputs 1 cycle later.
- load → display latency: the value appears on the first frame boundary at or after the load edge. Worst case is DIGITS*REFRESH_DIV cycles.
- Each digit is lit for exactly REFRESH_DIV cycles. Frame period is DIGITS*REFRESH_DIV cycles.
- Never more than one anode is low in any cycle.

## Test plan
Configuration for all scenarios: DIGITS=4, REFRESH_DIV=4.
- Reset/scan:
  - Stimulus: hold RST=0 for 3 cycles, then release with en=1.
  - Required: an=F until release. Then an sequences E,D,B,7,E… with each value held for 4 cycles. seg=40 throughout.
- Decode sweep:
  - Stimulus: load value=0x3210, then 0x7654, 0xBA98, 0xFEDC, one per frame.
  - Required: every digit shows the table code for its nibble, e.g. digit 3 of 0xFEDC → 0E.
- Tear-free load:
  - Stimulus: load 0x1234 while digit_idx=1, then load 0xABCD while digit_idx=2 of the same frame.
  - Required: the old value is kept to the end of the frame. The next frame shows 0xABCD, and 0x1234 is never displayed.
- Load at boundary:
  - Stimulus: pulse load with 0x5555 in the frame-boundary cycle.
  - Required: digit 0 shows 12 on the very next edge.
- Leading zeros:
  - Stimulus: value=0x0040 with blank_lz=1, then value=0x0000.
  - Required: for 0x0040, digits 3 and 2 give seg=7F, digit 1 gives 19, digit 0 gives 40. For 0x0000, only digit 0 shows 40.
- Enable/dp:
  - Stimulus: dp=4'b0100 loaded, then en dropped for 5 cycles.
  - Required: dp_n=0 only while an=B. During en=0, an=F, seg=7F and dp_n=1, while digit_idx keeps advancing. The scan resumes in phase when en returns.
